// File: rtl/spi_xform_slave_if.sv
// SPI pin bundle between a master and the transform slave.
// The slave samples sck/ss/mosi in its own clock domain; miso is driven by the slave only.
interface spi_xform_slave_if;
    logic sck;
    logic ss;
    logic mosi;
    logic miso;

    modport master (output sck, output ss, output mosi, input miso);
    modport slave  (input sck, input ss, input mosi, output miso);
endinterface

// File: rtl/spi_xform_slave.sv
// SPI slave test peripheral: receives a DATA_W-bit word on mosi, then returns a
// transformed copy of it on miso in the second half of the frame. sck/ss/mosi are
// oversampled in the system clock domain. done/abort are single-cycle pulses and
// are never high together; frame_cnt counts completed frames modulo 2^CNT_W.
module spi_xform_slave #(
    parameter int DATA_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clock,
    input  logic                resetn,
    spi_xform_slave_if.slave    spi,
    input  logic [1:0]          op,
    output logic                done,
    output logic                abort,
    output logic [DATA_W-1:0]   last_rx,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [1:0]          dbg_state
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int PTR_W = $clog2(DATA_W);
    localparam logic SCK_IDLE = (CPOL != 0);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W-1:0] PTR_FIRST = (MSB_FIRST != 0) ? PTR_W'(DATA_W - 1) : '0;
    localparam logic [PTR_W-1:0] PTR_LAST  = (MSB_FIRST != 0) ? '0 : PTR_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_TX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                sck_meta_q, sck_sync_q, sck_prev_q;
    logic                ss_meta_q, ss_sync_q, ss_prev_q;
    logic                mosi_meta_q, mosi_sync_q;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                tx_seen_q, tx_seen_d;
    logic [DATA_W-1:0]   last_rx_q, last_rx_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic                sck_rise, sck_fall, lead_edge, trail_edge;
    logic                sample_edge, shift_edge, ss_fall;
    logic [DATA_W-1:0]   rx_word;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w, input logic [1:0] sel);
        logic [DATA_W-1:0] rev;
        logic [DATA_W-1:0] inv_rev;
        for (int i = 0; i < DATA_W; i++) begin
            rev[i]     = w[DATA_W-1-i];
            inv_rev[i] = ~w[DATA_W-1-i];
        end
        case (sel)
            2'b00:   return rev;
            2'b01:   return w;
            2'b10:   return ~w;
            default: return inv_rev;
        endcase
    endfunction

    // Two-flop synchronisers on every pin, plus previous-value flops for edge detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_meta_q  <= SCK_IDLE;
            sck_sync_q  <= SCK_IDLE;
            sck_prev_q  <= SCK_IDLE;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= spi.sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= spi.ss;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= spi.mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sck_rise    = sck_sync_q & ~sck_prev_q;
    assign sck_fall    = ~sck_sync_q & sck_prev_q;
    assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
    assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_sync_q & ss_prev_q;

    // Receive shift register with the newly sampled bit folded in, in wire order.
    assign rx_word = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], mosi_sync_q}
                                      : {mosi_sync_q, rx_sh_q[DATA_W-1:1]};

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            tx_seen_q   <= 1'b0;
            last_rx_q   <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            tx_seen_q   <= tx_seen_d;
            last_rx_q   <= last_rx_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    // Frame sequencing: ss high always wins over a same-cycle sck edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        tx_seen_d   = tx_seen_q;
        last_rx_d   = last_rx_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d   = S_RX;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                end
            end
            S_RX: begin
                if (ss_sync_q) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (sample_edge) begin
                    rx_sh_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        last_rx_d = rx_word;
                        tx_d      = xform(rx_word, op);
                        ptr_d     = PTR_FIRST;
                        tx_seen_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_TX;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_TX: begin
                if (ss_sync_q) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (sample_edge) begin
                    tx_seen_d = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge && tx_seen_q && (ptr_q != PTR_LAST)) begin
                    // The first bit is already on the wire at TX entry, so the pointer
                    // only moves once the master has sampled at least one TX bit.
                    ptr_d = (MSB_FIRST != 0) ? ptr_q - 1'b1 : ptr_q + 1'b1;
                end
            end
            S_DONE: begin
                if (ss_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign spi.miso  = (state_q == S_TX) ? tx_q[ptr_q] : 1'b1;
    assign done      = done_q;
    assign abort     = abort_q;
    assign last_rx   = last_rx_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_xform_slave.sv
// Bench for spi_xform_slave: five instances cover the SPI modes, a 16-bit LSB-first
// word and a 2-bit frame counter. A bit-level SPI master drives each instance; an
// event scoreboard and a word-level transform model give the expected results.
module tb_spi_xform_slave;

    localparam int N_DUT = 5;

    function automatic int cfg_dw(input int g);
        return (g == 3) ? 16 : 8;
    endfunction
    function automatic int cfg_cpol(input int g);
        return (g == 1 || g == 3) ? 1 : 0;
    endfunction
    function automatic int cfg_cpha(input int g);
        return (g == 1 || g == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_msb(input int g);
        return (g == 3) ? 0 : 1;
    endfunction
    function automatic int cfg_cnt(input int g);
        return (g == 4) ? 2 : 16;
    endfunction
    function automatic logic [31:0] dmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Word-level transform model: reversal built arithmetically, one bit at a time.
    function automatic logic [31:0] model_xform(input logic [31:0] w, input logic [1:0] opv, input int dw);
        logic [31:0] src;
        logic [31:0] rev;
        src = w & dmask(dw);
        if (opv == 2'b01) return src;
        if (opv[1]) src = ~src & dmask(dw);
        if (opv == 2'b10) return src;
        rev = 0;
        for (int i = 0; i < dw; i++) rev = (rev << 1) | ((src >> i) & 32'd1);
        return rev;
    endfunction

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    logic [N_DUT-1:0] sck_r, ss_r, mosi_r;
    logic [1:0]       op_r [N_DUT];
    logic [N_DUT-1:0] done_all, abort_all, miso_all;
    logic [31:0]      lrx_all [N_DUT];
    logic [31:0]      fc_all [N_DUT];
    logic [1:0]       dbg_all [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        localparam int CW = cfg_cnt(g);
        logic [DW-1:0] lrx;
        logic [CW-1:0] fc;
        logic          dn, ab;
        logic [1:0]    st;
        spi_xform_slave_if u_if ();
        assign u_if.sck  = sck_r[g];
        assign u_if.ss   = ss_r[g];
        assign u_if.mosi = mosi_r[g];
        spi_xform_slave #(
            .DATA_W(DW), .CPOL(cfg_cpol(g)), .CPHA(cfg_cpha(g)),
            .MSB_FIRST(cfg_msb(g)), .CNT_W(CW)
        ) u_dut (
            .clock(clock), .resetn(resetn), .spi(u_if), .op(op_r[g]),
            .done(dn), .abort(ab), .last_rx(lrx), .frame_cnt(fc), .dbg_state(st)
        );
        assign done_all[g]  = dn;
        assign abort_all[g] = ab;
        assign miso_all[g]  = u_if.miso;
        assign lrx_all[g]   = 32'(lrx);
        assign fc_all[g]    = 32'(fc);
        assign dbg_all[g]   = st;
    end

    // Scoreboard: {instance[35:33], is_done[32], expected last_rx[31:0]}
    logic [35:0] exp_q[$];
    int          cur_cnt [N_DUT];
    logic [31:0] model_last [N_DUT];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Every done/abort pulse must match the oldest expected event; frame_cnt tracks the model each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int g = 0; g < N_DUT; g++) begin
                if (done_all[g] || abort_all[g]) begin
                    logic [35:0] e;
                    chk("done_abort_exclusive", 32'(done_all[g] & abort_all[g]), 32'd0);
                    chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("event_instance", 32'(e[35:33]), 32'(g));
                        chk("event_is_done", 32'(done_all[g]), 32'(e[32]));
                        chk("event_last_rx", lrx_all[g], e[31:0]);
                        if (e[32]) cur_cnt[g]++;
                    end
                end
                chk("frame_cnt", fc_all[g], 32'(cur_cnt[g]) & dmask(cfg_cnt(g)));
            end
        end
    end

    // One frame from the master: nslots sck periods, the first DW carrying wr,
    // the next DW reading miso back. abandon leaves ss low and expects nothing.
    task automatic spi_frame(input int g, input logic [31:0] wr, input logic [1:0] opv,
                             input int nslots, input int hp, input bit abandon,
                             output logic [31:0] rd);
        int   dw;
        logic cpol, cpha, msb, b, smp;
        dw   = cfg_dw(g);
        cpol = (cfg_cpol(g) != 0);
        cpha = (cfg_cpha(g) != 0);
        msb  = (cfg_msb(g) != 0);
        wr   = wr & dmask(dw);
        rd   = '0;
        if (!abandon) begin
            if (nslots >= dw) model_last[g] = wr;
            exp_q.push_back({3'(g), (nslots >= 2 * dw), model_last[g]});
        end
        op_r[g] = opv;
        ss_r[g] = 1'b0;
        clk_wait(hp);
        for (int i = 0; i < nslots; i++) begin
            if (i < dw) b = msb ? wr[dw-1-i] : wr[i];
            else b = 1'($urandom_range(0, 1));
            if (!cpha) begin
                mosi_r[g] = b;
                clk_wait(hp);
                smp = miso_all[g];
                sck_r[g] = ~cpol;
                clk_wait(hp);
                sck_r[g] = cpol;
            end else begin
                sck_r[g]  = ~cpol;
                mosi_r[g] = b;
                clk_wait(hp);
                smp = miso_all[g];
                sck_r[g] = cpol;
                clk_wait(hp);
            end
            if (i >= dw && i < 2 * dw) begin
                if (msb) rd = (rd << 1) | 32'(smp);
                else rd = rd | (32'(smp) << (i - dw));
            end else if (i >= 2 * dw) begin
                chk("miso_after_done", 32'(smp), 32'd1);
            end
        end
        if (!abandon) begin
            if (!cpha) clk_wait(hp);
            ss_r[g] = 1'b1;
            clk_wait(8);
            chk("events_drained", 32'(exp_q.size()), 32'd0);
            chk("miso_idle", 32'(miso_all[g]), 32'd1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wr;
        logic [1:0]  opv;
        int          dw, ns, hp;

        for (int g = 0; g < N_DUT; g++) begin
            sck_r[g]      = (cfg_cpol(g) != 0);
            ss_r[g]       = 1'b1;
            mosi_r[g]     = 1'b0;
            op_r[g]       = 2'b00;
            cur_cnt[g]    = 0;
            model_last[g] = '0;
        end
        #1 resetn = 1'b0;
        clk_wait(4);
        resetn = 1'b1;
        clk_wait(2);
        for (int g = 0; g < N_DUT; g++) begin
            chk("reset_miso", 32'(miso_all[g]), 32'd1);
            chk("reset_done", 32'(done_all[g]), 32'd0);
            chk("reset_abort", 32'(abort_all[g]), 32'd0);
            chk("reset_last_rx", lrx_all[g], 32'd0);
            chk("reset_frame_cnt", fc_all[g], 32'd0);
            chk("reset_state_idle", 32'(dbg_all[g]), 32'd0);
        end
        chk_en = 1'b1;

        // Mode 0, bit reverse of 0x01.
        spi_frame(0, 32'h01, 2'b00, 16, 6, 1'b0, rd);
        chk("t1_read", rd, 32'h80);
        chk("t1_frame_cnt", fc_all[0], 32'd1);
        chk("t1_last_rx", lrx_all[0], 32'h01);

        // Mode 3 invert, mode 1 reverse-of-inverted.
        spi_frame(1, 32'hA5, 2'b10, 16, 7, 1'b0, rd);
        chk("t2_mode3_invert", rd, 32'h5A);
        spi_frame(2, 32'hF0, 2'b11, 16, 6, 1'b0, rd);
        chk("t2_mode1_revinv", rd, 32'hF0);

        // 16-bit LSB-first echo.
        spi_frame(3, 32'h1234, 2'b01, 32, 6, 1'b0, rd);
        chk("t3_echo16", rd, 32'h1234);
        chk("t3_last_rx", lrx_all[3], 32'h1234);

        // Abort after five received bits, then a clean frame.
        spi_frame(0, 32'h3C, 2'b00, 5, 6, 1'b0, rd);
        chk("t4_abort_miso", 32'(miso_all[0]), 32'd1);
        chk("t4_abort_frame_cnt", fc_all[0], 32'd1);
        chk("t4_abort_last_rx", lrx_all[0], 32'h01);
        spi_frame(0, 32'h03, 2'b00, 16, 6, 1'b0, rd);
        chk("t4_read", rd, 32'hC0);

        // 40 extra sck periods after a complete frame.
        spi_frame(0, 32'h96, 2'b01, 16 + 40, 6, 1'b0, rd);
        chk("t5_read", rd, 32'h96);
        chk("t5_frame_cnt", fc_all[0], 32'd3);

        // Randomised frames on every instance, some cut short by ss.
        for (int g = 0; g < N_DUT; g++) begin
            dw = cfg_dw(g);
            for (int k = 0; k < 6; k++) begin
                wr  = $urandom & dmask(dw);
                opv = 2'($urandom_range(0, 3));
                hp  = $urandom_range(6, 9);
                ns  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * dw - 1) : 2 * dw;
                spi_frame(g, wr, opv, ns, hp, 1'b0, rd);
                if (ns == 2 * dw) chk("rand_read", rd, model_xform(wr, opv, dw));
            end
        end

        // Reset in the middle of the TX half.
        spi_frame(0, 32'h5A, 2'b00, 8 + 3, 6, 1'b1, rd);
        resetn = 1'b0;
        for (int g = 0; g < N_DUT; g++) begin
            cur_cnt[g]    = 0;
            model_last[g] = '0;
        end
        #1;
        chk("t6_reset_miso", 32'(miso_all[0]), 32'd1);
        chk("t6_reset_frame_cnt", fc_all[0], 32'd0);
        chk("t6_reset_last_rx", lrx_all[0], 32'd0);
        chk("t6_reset_abort", 32'(abort_all[0]), 32'd0);
        for (int g = 0; g < N_DUT; g++) begin
            ss_r[g]  = 1'b1;
            sck_r[g] = (cfg_cpol(g) != 0);
        end
        clk_wait(3);
        resetn = 1'b1;
        clk_wait(4);

        // 2-bit frame counter wraps after four frames.
        for (int k = 0; k < 3; k++) begin
            wr = $urandom & 32'hFF;
            spi_frame(4, wr, 2'b00, 16, 6, 1'b0, rd);
            chk("t6_cnt2_read", rd, model_xform(wr, 2'b00, 8));
        end
        chk("t6_cnt2_three", fc_all[4], 32'd3);
        spi_frame(4, 32'h81, 2'b10, 16, 6, 1'b0, rd);
        chk("t6_cnt2_read4", rd, 32'h7E);
        chk("t6_cnt2_wrap", fc_all[4], 32'd0);

        clk_wait(4);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
